// File: rtl/wb_core_arbiter_pkg.sv
// wb_arb_pkg: shared types for the core Wishbone arbiter.
//   arb_state_e : arbiter FSM states (idle, owned by m0, owned by m1)
//   M_IF/M_MEM  : master indices (m0 = IF stage, m1 = MEM stage)
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam int M_IF  = 0;
  localparam int M_MEM = 1;

endpackage

// File: rtl/wb_core_arbiter_if.sv
// wb_core_arbiter_if: one classic Wishbone point-to-point link.
//   cyc/stb/we/adr/dat_w/sel : master -> slave
//   dat_r/ack/err            : slave -> master
// modport master is the bus initiator side, modport slave the responder side.
interface wb_core_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_w;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] dat_r;
  logic              ack;
  logic              err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_core_arbiter_rr2.sv
// arb_rr2: two-way round-robin picker.
//   clk, rstn_i : clock, async active-low reset
//   req[1:0]    : request per master (bit0 m0, bit1 m1)
//   en          : picking allowed this cycle
//   gnt[1:0]    : one-hot pick (combinational), 00 when disabled or no request
// Owns last_q, the most recently granted master; it resets to m1 so m0 wins
// the first contended pick.
module arb_rr2
  import wb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rstn_i,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == 1'(M_MEM)) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      last_q <= 1'(M_MEM);
    end else if (gnt[0]) begin
      last_q <= 1'(M_IF);
    end else if (gnt[1]) begin
      last_q <= 1'(M_MEM);
    end
  end

endmodule

// File: rtl/wb_core_arbiter.sv
// wb_core_arbiter: shares one Wishbone slave between the core IF master (m0)
// and MEM master (m1). Round-robin pick, grant locked for a whole cyc,
// per-transfer watchdog, and a debug halt that blocks new grants.
//   clk, rstn_i : clock, async active-low reset
//   halt_i      : no new grant while high (an owned cycle still completes)
//   m0, m1      : master links (arbiter is their slave)
//   s           : link to the shared slave (arbiter is its master)
//   grant_o     : one-hot registered owner, 00 when idle
//   timeout_o   : one-cycle pulse when the watchdog aborts a transfer
//
// state    | meaning
// ARB_IDLE | no owner, slave outputs 0, picking when halt_i low
// ARB_OWN0 | m0 owns the slave until it drops cyc or the watchdog fires
// ARB_OWN1 | m1 owns the slave until it drops cyc or the watchdog fires
module wb_core_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    halt_i,
  wb_core_arbiter_if.slave        m0,
  wb_core_arbiter_if.slave        m1,
  wb_core_arbiter_if.master       s,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam int SEL_W = DATA_W / 8;
  // A zero-width counter is illegal, so the disabled watchdog keeps one idle bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  arb_state_e        state_q;
  logic [1:0]        grant_q;
  logic [CNT_W-1:0]  wd_cnt_q;
  logic [1:0]        pick;
  logic              pick_en;
  logic              own0;
  logic              own1;
  logic              owned;
  logic              own_stb;
  logic              wd_fire;
  logic              cyc_mux;
  logic              stb_mux;
  logic              we_mux;
  logic [ADDR_W-1:0] adr_mux;
  logic [DATA_W-1:0] dat_mux;
  logic [SEL_W-1:0]  sel_mux;

  assign own0    = (state_q == ARB_OWN0);
  assign own1    = (state_q == ARB_OWN1);
  assign owned   = own0 | own1;
  assign pick_en = (state_q == ARB_IDLE) & ~halt_i;
  assign own_stb = (own0 & m0.stb) | (own1 & m1.stb);
  assign wd_fire = (TIMEOUT != 0) && owned && (wd_cnt_q == TO_CNT);

  arb_rr2 u_rr2 (
    .clk    (clk),
    .rstn_i (rstn_i),
    .req    ({m1.cyc, m0.cyc}),
    .en     (pick_en),
    .gnt    (pick)
  );

  always_comb begin
    cyc_mux = 1'b0;
    stb_mux = 1'b0;
    we_mux  = 1'b0;
    adr_mux = '0;
    dat_mux = '0;
    sel_mux = '0;
    if (own0) begin
      cyc_mux = m0.cyc;
      stb_mux = m0.stb;
      we_mux  = m0.we;
      adr_mux = m0.adr;
      dat_mux = m0.dat_w;
      sel_mux = m0.sel;
    end else if (own1) begin
      cyc_mux = m1.cyc;
      stb_mux = m1.stb;
      we_mux  = m1.we;
      adr_mux = m1.adr;
      dat_mux = m1.dat_w;
      sel_mux = m1.sel;
    end
  end

  // The watchdog abort drops cyc/stb towards the slave in the firing cycle.
  assign s.cyc   = cyc_mux & ~wd_fire;
  assign s.stb   = stb_mux & ~wd_fire;
  assign s.we    = we_mux;
  assign s.adr   = adr_mux;
  assign s.dat_w = dat_mux;
  assign s.sel   = sel_mux;

  assign m0.ack   = own0 & s.ack & ~wd_fire;
  assign m0.err   = own0 & (s.err | wd_fire);
  assign m0.dat_r = own0 ? s.dat_r : '0;
  assign m1.ack   = own1 & s.ack & ~wd_fire;
  assign m1.err   = own1 & (s.err | wd_fire);
  assign m1.dat_r = own1 ? s.dat_r : '0;

  assign grant_o   = grant_q;
  assign timeout_o = wd_fire;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ARB_IDLE;
      grant_q <= 2'b00;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick[0]) begin
            state_q <= ARB_OWN0;
            grant_q <= 2'b01;
          end else if (pick[1]) begin
            state_q <= ARB_OWN1;
            grant_q <= 2'b10;
          end
        end
        ARB_OWN0: begin
          if (!m0.cyc || wd_fire) begin
            state_q <= ARB_IDLE;
            grant_q <= 2'b00;
          end
        end
        ARB_OWN1: begin
          if (!m1.cyc || wd_fire) begin
            state_q <= ARB_IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  // Counts stalled strobe cycles; saturates at TIMEOUT instead of wrapping.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wd_cnt_q <= '0;
    end else if (!owned || wd_fire || !own_stb || s.err || s.ack) begin
      wd_cnt_q <= '0;
    end else if ((TIMEOUT != 0) && (wd_cnt_q != TO_CNT)) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_core_arbiter.sv
module tb_wb_core_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       halt;
  logic [1:0] grant;
  logic       timeout;
  int         checks = 0;
  int         errors = 0;

  wb_core_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  wb_core_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  wb_core_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

  wb_core_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rstn_i    (rstn),
    .halt_i    (halt),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .grant_o   (grant),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.adr = '0; m0_if.dat_w = '0; m0_if.sel = 4'hF;
    m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.adr = '0; m1_if.dat_w = '0; m1_if.sel = 4'hF;
    s_if.ack = 0; s_if.err = 0; s_if.dat_r = '0;
  endtask

  task automatic test_reset();
    rstn = 0; halt = 0;
    idle_masters();
    s_if.ack = 1; s_if.dat_r = 32'hFFFF_FFFF;
    #3;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b expected 0", s_if.cyc); end
    checks++; if (m0_if.ack !== 1'b0) begin errors++; $display("FAIL reset_m0_ack: got %b expected 0", m0_if.ack); end
    checks++; if (m1_if.dat_r !== 32'h0) begin errors++; $display("FAIL reset_m1_dat: got %h expected 0", m1_if.dat_r); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    tick();
    rstn = 1; s_if.ack = 0; s_if.dat_r = '0;
    // reset in the middle of an owned transfer
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h40;
    tick();
    checks++; if (s_if.cyc !== 1'b1) begin errors++; $display("FAIL midrst_own_cyc: got %b expected 1", s_if.cyc); end
    s_if.ack = 1;
    #2 rstn = 0;
    #1;
    checks++; if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL midrst_s_cyc: got %b expected 0", s_if.cyc); end
    checks++; if (s_if.stb !== 1'b0) begin errors++; $display("FAIL midrst_s_stb: got %b expected 0", s_if.stb); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL midrst_grant: got %b expected 00", grant); end
    checks++; if (m0_if.ack !== 1'b0) begin errors++; $display("FAIL midrst_m0_ack: got %b expected 0", m0_if.ack); end
    idle_masters();
    tick();
    rstn = 1;
    tick();
  endtask

  task automatic test_single();
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.we = 0; m1_if.adr = 32'h100;
    #1;
    checks++; if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL single_latency: got %b expected 0", s_if.cyc); end
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL single_grant: got %b expected 10", grant); end
    checks++; if (s_if.adr !== 32'h100) begin errors++; $display("FAIL single_adr: got %h expected 100", s_if.adr); end
    checks++; if (s_if.stb !== 1'b1) begin errors++; $display("FAIL single_stb: got %b expected 1", s_if.stb); end
    tick();
    checks++; if (m1_if.ack !== 1'b0) begin errors++; $display("FAIL single_early_ack: got %b expected 0", m1_if.ack); end
    tick();
    s_if.ack = 1; s_if.dat_r = 32'hDEADBEEF;
    #1;
    checks++; if (m1_if.ack !== 1'b1) begin errors++; $display("FAIL single_ack: got %b expected 1", m1_if.ack); end
    checks++; if (m1_if.dat_r !== 32'hDEADBEEF) begin errors++; $display("FAIL single_dat: got %h expected deadbeef", m1_if.dat_r); end
    checks++; if (m0_if.ack !== 1'b0) begin errors++; $display("FAIL single_m0_ack: got %b expected 0", m0_if.ack); end
    checks++; if (m0_if.dat_r !== 32'h0) begin errors++; $display("FAIL single_m0_dat: got %h expected 0", m0_if.dat_r); end
    tick();
    s_if.ack = 0; s_if.dat_r = '0; m1_if.cyc = 0; m1_if.stb = 0;
    #1;
    checks++; if (m1_if.ack !== 1'b0) begin errors++; $display("FAIL single_ack_1cyc: got %b expected 0", m1_if.ack); end
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL single_grant_hold: got %b expected 10", grant); end
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_release: got %b expected 00", grant); end
  endtask

  task automatic test_contention();
    tick();
    rstn = 0; #1 rstn = 1;
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h10;
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h20;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cont_req_cycle: got %b expected 00", grant); end
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cont_first_m0: got %b expected 01", grant); end
    checks++; if (s_if.adr !== 32'h10) begin errors++; $display("FAIL cont_adr_m0: got %h expected 10", s_if.adr); end
    // owner drops cyc in the same cycle the slave acks
    m0_if.cyc = 0; m0_if.stb = 0; s_if.ack = 1;
    #1;
    checks++; if (m0_if.ack !== 1'b1) begin errors++; $display("FAIL cont_drop_ack: got %b expected 1", m0_if.ack); end
    checks++; if (m1_if.ack !== 1'b0) begin errors++; $display("FAIL cont_nonowner_ack: got %b expected 0", m1_if.ack); end
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cont_idle_gap: got %b expected 00", grant); end
    checks++; if (m1_if.ack !== 1'b0) begin errors++; $display("FAIL cont_idle_ack_ignored: got %b expected 0", m1_if.ack); end
    checks++; if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL cont_idle_cyc: got %b expected 0", s_if.cyc); end
    s_if.ack = 0;
    m0_if.cyc = 1; m0_if.stb = 1;
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL cont_second_m1: got %b expected 10", grant); end
    checks++; if (s_if.adr !== 32'h20) begin errors++; $display("FAIL cont_adr_m1: got %h expected 20", s_if.adr); end
    m1_if.cyc = 0; m1_if.stb = 0;
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cont_idle_gap2: got %b expected 00", grant); end
    m1_if.cyc = 1; m1_if.stb = 1;
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cont_third_m0: got %b expected 01", grant); end
    idle_masters();
    tick();
    tick();
  endtask

  task automatic test_lock();
    logic [31:0] beat_dat [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h300;
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL lock_grant: got %b expected 01", grant); end
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h900;
    for (int i = 0; i < 4; i++) begin
      m0_if.adr = 32'h300 + 32'(4 * i);
      s_if.ack = 1; s_if.dat_r = beat_dat[i];
      #1;
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL lock_beat%0d_grant: got %b expected 01", i, grant); end
      checks++; if (m0_if.dat_r !== beat_dat[i]) begin errors++; $display("FAIL lock_beat%0d_dat: got %h expected %h", i, m0_if.dat_r, beat_dat[i]); end
      checks++; if (m1_if.ack !== 1'b0) begin errors++; $display("FAIL lock_beat%0d_m1_ack: got %b expected 0", i, m1_if.ack); end
      tick();
    end
    s_if.ack = 0; s_if.dat_r = '0; m0_if.cyc = 0; m0_if.stb = 0;
    #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL lock_drop_cycle: got %b expected 01", grant); end
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL lock_idle: got %b expected 00", grant); end
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL lock_m1_after: got %b expected 10", grant); end
    checks++; if (s_if.adr !== 32'h900) begin errors++; $display("FAIL lock_m1_adr: got %h expected 900", s_if.adr); end
    idle_masters();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.we = 1; m0_if.adr = 32'h200; m0_if.dat_w = 32'h5A5A_5A5A;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++; if (s_if.stb !== 1'b1 || m0_if.err !== 1'b0 || timeout !== 1'b0) begin
        errors++; $display("FAIL to_wait%0d: got stb=%b err=%b to=%b expected stb=1 err=0 to=0", i, s_if.stb, m0_if.err, timeout);
      end
      tick();
    end
    checks++; if (m0_if.err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", m0_if.err); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", timeout); end
    checks++; if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL to_s_cyc: got %b expected 0", s_if.cyc); end
    checks++; if (s_if.stb !== 1'b0) begin errors++; $display("FAIL to_s_stb: got %b expected 0", s_if.stb); end
    m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0;
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to_idle: got %b expected 00", grant); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_one_cycle: got %b expected 0", timeout); end
    tick();
  endtask

  task automatic test_halt();
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h500;
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL halt_m1_grant: got %b expected 10", grant); end
    halt = 1;
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h600;
    tick();
    s_if.ack = 1; s_if.dat_r = 32'hCAFE_0001;
    #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL halt_keep_owner: got %b expected 10", grant); end
    checks++; if (m1_if.ack !== 1'b1) begin errors++; $display("FAIL halt_m1_ack: got %b expected 1", m1_if.ack); end
    checks++; if (m1_if.dat_r !== 32'hCAFE_0001) begin errors++; $display("FAIL halt_m1_dat: got %h expected cafe0001", m1_if.dat_r); end
    tick();
    s_if.ack = 0; s_if.dat_r = '0; m1_if.cyc = 0; m1_if.stb = 0;
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL halt_idle: got %b expected 00", grant); end
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL halt_blocks_m0: got %b expected 00", grant); end
    checks++; if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL halt_s_cyc: got %b expected 0", s_if.cyc); end
    halt = 0;
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL halt_release: got %b expected 01", grant); end
    checks++; if (s_if.adr !== 32'h600) begin errors++; $display("FAIL halt_m0_adr: got %h expected 600", s_if.adr); end
    idle_masters();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_timeout();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
